// File: rtl/uart_flash_loader.sv
// uart_flash_loader: UART 8N1 boot loader (clk, rst async active-low, uart_rx -> flash_en/flash_addr/flash_data, cpu_rst, busy, error); define LOADER_CHECKSUM_EN for a trailing XOR checksum byte
module uart_flash_loader #(
    parameter int WIDTH        = 32,
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_WORDS    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx,
    output logic             flash_en,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             cpu_rst,
    output logic             busy,
    output logic             error
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]   MAX_LEN   = 17'(MAX_WORDS);
    localparam logic [7:0]    SYNC      = 8'hA5;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} ld_state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam ld_state_t AFTER_DATA = CSUM;
`else
    localparam ld_state_t AFTER_DATA = DONE;
`endif

    logic            rx_meta, rx_sync, rx_last;
    rx_state_t       rx_st, rx_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [2:0]      bit_cnt, bit_nx;
    logic [7:0]      sh, sh_nx;
    logic            byte_valid, frame_err;

    ld_state_t       ld_st, ld_nx;
    logic [15:0]     len, len_nx, idx, idx_nx;
    logic [1:0]      lane, lane_nx;
    logic [23:0]     word, word_nx;
    logic            en_nx;
    logic [WIDTH-1:0] addr_nx, data_nx;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      csum, csum_nx;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_last <= 1'b1;
            rx_st   <= R_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sh      <= '0;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_last <= rx_sync;
            rx_st   <= rx_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_nx;
            sh      <= sh_nx;
        end
    end

    // Start bit is confirmed at half a bit; data and stop bits are then sampled at mid-bit.
    always_comb begin
        rx_nx      = rx_st;
        cnt_nx     = cnt + 1'b1;
        bit_nx     = bit_cnt;
        sh_nx      = sh;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_st)
            R_IDLE: begin
                cnt_nx = '0;
                if (rx_last && !rx_sync) rx_nx = R_START;
            end
            R_START: if (cnt == HALF_LAST) begin
                cnt_nx = '0;
                bit_nx = '0;
                rx_nx  = rx_sync ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt == BIT_LAST) begin
                cnt_nx = '0;
                sh_nx  = {rx_sync, sh[7:1]};
                bit_nx = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) rx_nx = R_STOP;
            end
            default: if (cnt == BIT_LAST) begin
                rx_nx      = R_IDLE;
                byte_valid = rx_sync;
                frame_err  = !rx_sync;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_st      <= IDLE;
            len        <= '0;
            idx        <= '0;
            lane       <= '0;
            word       <= '0;
            flash_en   <= 1'b0;
            flash_addr <= '0;
            flash_data <= '0;
            busy       <= 1'b0;
            error      <= 1'b0;
            cpu_rst    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            ld_st      <= ld_nx;
            len        <= len_nx;
            idx        <= idx_nx;
            lane       <= lane_nx;
            word       <= word_nx;
            flash_en   <= en_nx;
            flash_addr <= addr_nx;
            flash_data <= data_nx;
            busy       <= ld_nx inside {LEN_LO, LEN_HI, DATA, CSUM};
            error      <= ld_nx == ERR;
            cpu_rst    <= ld_nx != DONE;
`ifdef LOADER_CHECKSUM_EN
            csum       <= csum_nx;
`endif
        end
    end

    always_comb begin
        ld_nx   = ld_st;
        len_nx  = len;
        idx_nx  = idx;
        lane_nx = lane;
        word_nx = word;
        en_nx   = 1'b0;
        addr_nx = flash_addr;
        data_nx = flash_data;
`ifdef LOADER_CHECKSUM_EN
        csum_nx = csum;
`endif
        if (frame_err && ld_st != IDLE) begin
            ld_nx = ERR;
        end else if (byte_valid) begin
            case (ld_st)
                IDLE, DONE, ERR: if (sh == SYNC) ld_nx = LEN_LO;
                LEN_LO: begin
                    len_nx = {8'h00, sh};
                    ld_nx  = LEN_HI;
                end
                LEN_HI: begin
                    len_nx  = {sh, len[7:0]};
                    idx_nx  = '0;
                    lane_nx = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_nx = '0;
`endif
                    ld_nx   = (len_nx == 16'd0) ? AFTER_DATA :
                              ({1'b0, len_nx} > MAX_LEN) ? ERR : DATA;
                end
                DATA: begin
                    // Lower three bytes accumulate in word; the fourth is merged directly into the write.
                    word_nx = {sh, word[23:8]};
                    lane_nx = lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_nx = csum ^ sh;
`endif
                    if (lane == 2'd3) begin
                        en_nx   = 1'b1;
                        addr_nx = WIDTH'({idx, 2'b00});
                        data_nx = WIDTH'({sh, word});
                        idx_nx  = idx + 16'd1;
                        if (idx == len - 16'd1) ld_nx = AFTER_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: ld_nx = (sh == csum) ? DONE : ERR;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_flash_loader.sv
// tb_uart_flash_loader: randomized and directed checks of uart_flash_loader against a byte-stream parsing model
module tb_uart_flash_loader;
    localparam int CPB  = 4;
    localparam int MAXW = 1024;

    logic        clk = 1'b0, rst = 1'b0, uart_rx = 1'b1;
    logic        flash_en, cpu_rst, busy, error;
    logic [31:0] flash_addr, flash_data;
    int          total = 0, bad = 0, b2b = 0;
    logic        en_prev = 1'b0;
    logic [7:0]  tx_b[$];
    bit          tx_ok[$];
    logic [31:0] exp_a[$], exp_d[$], got_a[$], got_d[$];
    int          exp_fin;

    always #5 clk = ~clk;

    uart_flash_loader #(.WIDTH(32), .CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .flash_en(flash_en),
        .flash_addr(flash_addr), .flash_data(flash_data), .cpu_rst(cpu_rst),
        .busy(busy), .error(error)
    );

    always @(negedge clk) begin
        if (flash_en) begin
            got_a.push_back(flash_addr);
            got_d.push_back(flash_data);
        end
        if (flash_en && en_prev) b2b++;
        en_prev = flash_en;
    end

    task automatic clear();
        tx_b.delete(); tx_ok.delete(); got_a.delete(); got_d.delete();
    endtask

    task automatic add(input logic [7:0] b, input bit ok);
        tx_b.push_back(b); tx_ok.push_back(ok);
    endtask

    task automatic add_csum(input int from, input bit corrupt);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] c = 8'h00;
        for (int i = from; i < tx_b.size(); i++) c ^= tx_b[i];
        add(corrupt ? c ^ 8'h01 : c, 1'b1);
`endif
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'hA5);
        return b;
    endfunction

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(ok);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic send_all();
        for (int i = 0; i < tx_b.size(); i++) send_byte(tx_b[i], tx_ok[i]);
        repeat (4 * CPB) @(negedge clk);
    endtask

    // Parses the queued byte stream frame by frame: exp_fin 0 idle, 1 done, 2 error, 3 mid-frame.
    task automatic model();
        int p = 0, sz = tx_b.size(), n, fin = 0;
        bit bd;
        logic [7:0] cs;
        logic [31:0] w;
        exp_a.delete(); exp_d.delete();
        while (p < sz) begin
            if (!tx_ok[p] || tx_b[p] != 8'hA5) begin
                if (!tx_ok[p] && fin != 0) fin = 2;
                p++;
            end else begin
                p++; bd = 0; n = 0; cs = 8'h00;
                for (int k = 0; k < 2 && !bd; k++) begin
                    if (p >= sz || !tx_ok[p]) bd = 1; else n += int'(tx_b[p]) << (8 * k);
                    p++;
                end
                if (!bd && n > MAXW) bd = 1;
                for (int i = 0; i < n && !bd; i++) begin
                    w = 32'h0;
                    for (int k = 0; k < 4 && !bd; k++) begin
                        if (p >= sz || !tx_ok[p]) bd = 1;
                        else begin w |= 32'(tx_b[p]) << (8 * k); cs ^= tx_b[p]; end
                        p++;
                    end
                    if (!bd) begin exp_a.push_back(32'(4 * i)); exp_d.push_back(w); end
                end
`ifdef LOADER_CHECKSUM_EN
                if (!bd) begin
                    if (p >= sz || !tx_ok[p] || tx_b[p] != cs) bd = 1;
                    p++;
                end
`endif
                fin = !bd ? 1 : (p > sz ? 3 : 2);
            end
        end
        exp_fin = fin;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({flash_en, flash_addr, flash_data, cpu_rst, busy, error} !== {1'b0, 64'h0, 1'b1, 2'b00}) begin
            bad++;
            $display("FAIL reset en=%b addr=%h data=%h rst=%b busy=%b err=%b want 0/0/0/1/0/0",
                     flash_en, flash_addr, flash_data, cpu_rst, busy, error);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        clear();
        add(8'hA5, 1); add(8'h01, 1); add(8'h00, 1); add(8'h11, 1); add(8'h22, 1);
        send_all();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got %b want 1", busy); end
        uart_rx = 1'b0;
        repeat (CPB + 2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({flash_en, flash_addr, flash_data, cpu_rst, busy, error} !== {1'b0, 64'h0, 1'b1, 2'b00}) begin
            bad++;
            $display("FAIL async_reset en=%b addr=%h data=%h rst=%b busy=%b err=%b want 0/0/0/1/0/0",
                     flash_en, flash_addr, flash_data, cpu_rst, busy, error);
        end
        @(negedge clk) uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        clear();
        add(8'hA5, 1); add(8'h01, 1); add(8'h00, 1);
        add(8'h78, 1); add(8'h56, 1); add(8'h34, 1); add(8'h12, 1);
        add_csum(3, 0);
        send_all();
        total++;
        if (got_a.size() != 1 || got_a[0] !== 32'h0 || got_d[0] !== 32'h12345678) begin
            bad++;
            $display("FAIL reload writes=%0d addr=%h data=%h want 1 write 0/12345678", got_a.size(),
                     got_a.size() ? got_a[0] : 32'hx, got_d.size() ? got_d[0] : 32'hx);
        end
    endtask

    task automatic test_two_words();
        logic [7:0] fr[11] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB3, 8'h85, 8'hA5, 8'h00};
        clear();
        foreach (fr[i]) add(fr[i], 1);
        add_csum(3, 0);
        send_all();
        total++;
        if (got_a.size() != 2) begin bad++; $display("FAIL two_words count got %0d want 2", got_a.size()); end
        else begin
            total++;
            if (got_a[0] !== 32'h0 || got_d[0] !== 32'h00A00513) begin
                bad++; $display("FAIL two_words w0 got %h/%h want 00000000/00a00513", got_a[0], got_d[0]);
            end
            total++;
            if (got_a[1] !== 32'h4 || got_d[1] !== 32'h00A585B3) begin
                bad++; $display("FAIL two_words w1 got %h/%h want 00000004/00a585b3", got_a[1], got_d[1]);
            end
        end
        total++;
        if ({busy, error, cpu_rst} !== 3'b000) begin
            bad++; $display("FAIL two_words status busy/err/rst got %b%b%b want 000", busy, error, cpu_rst);
        end
    endtask

    task automatic test_garbage_zero_len();
        clear();
        add(8'h00, 1); add(8'hFF, 1); add(8'h12, 1); add(8'hA5, 1);
        send_all();
        total++;
        if ({busy, cpu_rst} !== 2'b11) begin
            bad++; $display("FAIL restart busy/rst got %b%b want 11", busy, cpu_rst);
        end
        clear();
        add(8'h00, 1); add(8'h00, 1);
        add_csum(2, 0);
        send_all();
        total++;
        if (got_a.size() != 0 || {busy, error, cpu_rst} !== 3'b000) begin
            bad++; $display("FAIL zero_len writes=%0d status=%b%b%b want 0 writes 000", got_a.size(), busy, error, cpu_rst);
        end
    endtask

    task automatic test_too_long();
        clear();
        add(8'hA5, 1); add(8'h01, 1); add(8'h04, 1);
        send_all();
        total++;
        if (got_a.size() != 0 || {busy, error, cpu_rst} !== 3'b011) begin
            bad++; $display("FAIL too_long writes=%0d status=%b%b%b want 0 writes 011", got_a.size(), busy, error, cpu_rst);
        end
        clear();
        add(8'hA5, 1); add(8'h01, 1); add(8'h00, 1);
        for (int i = 0; i < 4; i++) add(rnd_byte(), 1);
        add_csum(3, 0);
        model();
        send_all();
        total++;
        if (got_a.size() != 1 || got_a[0] !== exp_a[0] || got_d[0] !== exp_d[0] || {busy, error, cpu_rst} !== 3'b000) begin
            bad++; $display("FAIL recover writes=%0d data=%h want 1 write %h status=%b%b%b want 000",
                            got_a.size(), got_d.size() ? got_d[0] : 32'hx, exp_d[0], busy, error, cpu_rst);
        end
    endtask

    task automatic test_framing_glitch();
        clear();
        add(8'hA5, 1); add(8'h01, 1); add(8'h00, 1); add(8'h11, 1); add(8'h22, 0);
        send_all();
        total++;
        if (got_a.size() != 0 || {busy, error, cpu_rst} !== 3'b011) begin
            bad++; $display("FAIL framing writes=%0d status=%b%b%b want 0 writes 011", got_a.size(), busy, error, cpu_rst);
        end
        clear();
        add(8'hA5, 1); add(8'h01, 1); add(8'h00, 1); add(8'h11, 1); add(8'h22, 1);
        send_all();
        uart_rx = 1'b0;
        @(negedge clk) uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        clear();
        add(8'h33, 1); add(8'h44, 1);
`ifdef LOADER_CHECKSUM_EN
        add(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1);
`endif
        send_all();
        total++;
        if (got_a.size() != 1 || got_d[0] !== 32'h44332211 || {busy, error, cpu_rst} !== 3'b000) begin
            bad++; $display("FAIL glitch writes=%0d data=%h want 1 write 44332211 status=%b%b%b want 000",
                            got_a.size(), got_d.size() ? got_d[0] : 32'hx, busy, error, cpu_rst);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int t = 0; t < 2; t++) begin
            clear();
            add(8'hA5, 1); add(8'h01, 1); add(8'h00, 1);
            add(8'h11, 1); add(8'h22, 1); add(8'h33, 1); add(8'h44, 1);
            add(t ? 8'h45 : 8'h44, 1);
            send_all();
            total++;
            if (got_a.size() != 1 || got_d[0] !== 32'h44332211 ||
                {busy, error, cpu_rst} !== (t ? 3'b011 : 3'b000)) begin
                bad++; $display("FAIL checksum%0d writes=%0d data=%h status=%b%b%b want 1 write 44332211 %s",
                                t, got_a.size(), got_d.size() ? got_d[0] : 32'hx, busy, error, cpu_rst, t ? "011" : "000");
            end
        end
    endtask
`endif

    task automatic test_random();
        int n, start, eb, ee, er;
        for (int f = 0; f < 14; f++) begin
            clear();
            repeat ($urandom_range(0, 2)) add(rnd_byte(), 1);
            add(8'hA5, 1);
            start = tx_b.size();
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXW + 1, MAXW + 40) : $urandom_range(0, 4);
            add(8'(n), 1); add(8'(n >> 8), 1);
            if (n <= MAXW) begin
                repeat (4 * n) add(rnd_byte(), 1);
                add_csum(start + 2, $urandom_range(0, 4) == 0);
                if (n > 0 && $urandom_range(0, 3) == 0) tx_ok[$urandom_range(start + 2, tx_b.size() - 1)] = 0;
            end
            model();
            send_all();
            total++;
            if (got_a.size() != exp_a.size()) begin
                bad++; $display("FAIL rand%0d count got %0d want %0d", f, got_a.size(), exp_a.size());
            end
            for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
                total++;
                if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
                    bad++; $display("FAIL rand%0d w%0d got %h/%h want %h/%h", f, i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
                end
            end
            eb = exp_fin == 3; ee = exp_fin == 2; er = exp_fin != 1;
            total++;
            if ({busy, error, cpu_rst} !== {1'(eb), 1'(ee), 1'(er)}) begin
                bad++; $display("FAIL rand%0d status got %b%b%b want %0d%0d%0d", f, busy, error, cpu_rst, eb, ee, er);
            end
        end
    endtask

    task automatic test_back_to_back();
        total++;
        if (b2b != 0) begin bad++; $display("FAIL back_to_back strobes got %0d want 0", b2b); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_two_words();
        test_garbage_zero_len();
        test_too_long();
        test_framing_glitch();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_flash_loader.md
Name: uart_flash_loader

Overview:
Serial boot loader that sits directly upstream of the CPU top level. It receives a framed program image over a UART line (8N1) and assembles little-endian 32-bit words. It drives the CPU's flash_en / flash_addr / flash_data program-load port and holds the CPU in reset until the image is fully written.

Parameters:
WIDTH, 32, data/address width of the flash-load port; must be 32.
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4.
MAX_WORDS, 1024, largest accepted image in words; larger length fields cause an error.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
uart_rx  input  1  asynchronous serial input, idle high
flash_en  output  1  one-cycle write strobe to the CPU program memory
flash_addr  output  WIDTH  byte address of the word being written
flash_data  output  WIDTH  word being written
cpu_rst  output  1  high holds the CPU in reset
busy  output  1  high while a frame is being received
error  output  1  sticky error flag for the current frame

Behaviour:
- Reset (rst low, asynchronous): all FSMs go to IDLE. flash_en=0, flash_addr=0, flash_data=0, cpu_rst=1, busy=0, error=0.
- UART RX path:
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge starts a bit timer. The start bit is re-checked at CLKS_PER_BIT/2; if it is high, this is a glitch and the receiver returns to idle.
  - 8 data bits are sampled LSB first at mid-bit.
  - Stop bit sampled low = framing error.
  - A byte_valid pulse is produced for one cycle at the stop-bit sample.
- Frame format: sync byte 0xA5, then LEN_LO, LEN_HI (16-bit word count N), then 4*N payload bytes. Each word's payload is byte0 = bits 7:0 ... byte3 = bits 31:24.
- Loader FSM states: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR.
  - IDLE: bytes other than 0xA5 are ignored. On 0xA5 go to LEN_LO, set busy=1, error=0, cpu_rst=1.
  - LEN_HI: after this byte, N=0 goes to DONE. N>MAX_WORDS goes to ERR. Otherwise go to DATA with word index=0 and byte lane=0.
  - DATA: each byte is shifted into its lane. On the 4th lane, flash_en pulses high for exactly one cycle, on the cycle after that byte's byte_valid. flash_addr = 4*index and flash_data = the assembled word are valid in the same cycle and held until the next write. The index then increments; after word N-1 go to DONE.
  - DONE: busy=0, cpu_rst=0. Receiving 0xA5 restarts a load (cpu_rst reasserts in the next cycle, and flash_addr restarts at 0).
  - ERR: busy=0, error=1, cpu_rst=1. Only 0xA5 leaves ERR (to LEN_LO, which clears error).
- Framing error in any non-IDLE state: go to ERR, discard the partial word, issue no write. A framing error in IDLE is ignored.
- Words already written before an error are not undone. The CPU stays in reset, so they are never executed.
- The byte counter and word index never wrap: index ≤ MAX_WORDS-1 is guaranteed by the length check.
- Minimum spacing between flash_en pulses is 4 byte times. There are no back-to-back strobes.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined: one extra byte follows the payload, equal to the XOR of all payload bytes (not sync or length). On match go to DONE; on mismatch go to ERR (error=1, cpu_rst stays 1). N=0 still expects a checksum byte of 0x00.
- Undefined: no checksum byte. DONE is entered immediately after the last payload word's write strobe.

Test Plan:
1. Assert rst low mid-frame (after 2 payload bytes) → outputs return to reset values at once. After release, a fresh frame loads correctly from address 0.
2. Send A5 02 00 13 05 A0 00 B3 85 A5 00 (CLKS_PER_BIT=4) → two flash_en pulses: addr 0x0 data 0x00A00513, then addr 0x4 data 0x00A585B3. busy then falls, cpu_rst falls, error=0.
3. Send bytes 00 FF 12, then A5 00 00 → garbage ignored; DONE entered with zero writes; cpu_rst=0.
4. Send A5, then length 0x0401 with MAX_WORDS=1024 → ERR: error=1, cpu_rst=1, no flash_en. A following valid frame clears error and completes.
5. Send A5 01 00 with stop bit forced low on the 2nd payload byte → ERR with no flash_en. A 0.25-bit low glitch on idle uart_rx produces no byte.
6. With LOADER_CHECKSUM_EN: A5 01 00 11 22 33 44 44 → write 0x44332211, then DONE. The same frame ending in checksum byte 45 → write occurs, then ERR with cpu_rst=1.
